// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver/transmitter family.
// Contents:
//   uart_state_e - receiver FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   dbits_e      - cfg_dbits encoding (data bits minus DBITS_BASE)
//   OVS_DEFAULT / DBIT_MAX_DEFAULT - default oversampling ratio and data width
//   maj3         - 2-of-3 majority helper used by the optional vote filter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    DBITS_5 = 2'd0,
    DBITS_6 = 2'd1,
    DBITS_7 = 2'd2,
    DBITS_8 = 2'd3
  } dbits_e;

  localparam int DBITS_BASE       = 5;
  localparam int OVS_DEFAULT      = 16;
  localparam int DBIT_MAX_DEFAULT = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high; both stages load RESET_VAL
//   d     - asynchronous input
//   q     - synchronised output (second stage)
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage shift toward the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= RESET_VAL;
      q_r    <= RESET_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver, OVS-times oversampling on s_tick.
// Frame: start, 5..8 data bits LSB first, optional even/odd parity, 1 or 2 stop.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN - each bit decision is the
// 2-of-3 majority of the line over the three s_ticks ending at the decision tick.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   rx                  - asynchronous serial line, idle high
//   s_tick              - oversample enable, OVS pulses per bit
//   cfg_dbits           - data bits minus 5, clamped to DBIT_MAX
//   cfg_par_en/par_odd  - parity present / odd parity
//   cfg_stop2           - two stop bits
//   rx_dout             - received data, right-aligned
//   rx_done_tick        - one-cycle frame-complete pulse
//   parity_err, frame_err, break_det - status of the last frame
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT_MAX = DBIT_MAX_DEFAULT,
  parameter int OVS      = OVS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  input  logic                s_tick,
  input  logic [1:0]          cfg_dbits,
  input  logic                cfg_par_en,
  input  logic                cfg_par_odd,
  input  logic                cfg_stop2,
  output logic [DBIT_MAX-1:0] rx_dout,
  output logic                rx_done_tick,
  output logic                parity_err,
  output logic                frame_err,
  output logic                break_det
);

  localparam int SW = $clog2(OVS);
  localparam int NW = (DBIT_MAX > 1) ? $clog2(DBIT_MAX) : 1;
  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  logic rxs_s;
  logic bit_s;
  logic [3:0] dbits_cnt_s;

  uart_state_e state_r, state_nxt_s;
  logic [SW-1:0]       s_r, s_nxt_s;
  logic [NW-1:0]       n_r, n_nxt_s;
  logic [DBIT_MAX-1:0] data_r, data_nxt_s;
  logic xor_r, xor_nxt_s;
  logic zero_r, zero_nxt_s;        // every bit counted toward break was 0
  logic ferr_r, ferr_nxt_s;
  logic perr_r, perr_nxt_s;
  logic stop_sec_r, stop_sec_nxt_s; // currently sampling the second stop bit
  logic [NW-1:0] last_n_r, last_n_nxt_s;
  logic par_en_r, par_en_nxt_s;
  logic par_odd_r, par_odd_nxt_s;
  logic stop2_r, stop2_nxt_s;
  logic done_nxt_s;

  logic [DBIT_MAX-1:0] rx_dout_r;
  logic done_r;
  logic perr_out_r;
  logic ferr_out_r;
  logic brk_out_r;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs_s)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [2:0] smp_r;

  // Line history over the last three s_ticks; bit 0 is the newest sample
  always_ff @(posedge clk) begin
    if (reset) begin
      smp_r <= 3'b111;
    end else if (s_tick) begin
      smp_r <= {smp_r[1:0], rxs_s};
    end else begin
      smp_r <= smp_r;
    end
  end

  // The decision tick itself supplies the third sample, so the vote adds no latency
  assign bit_s = maj3(smp_r[1], smp_r[0], rxs_s);
`else
  assign bit_s = rxs_s;
`endif

  // Data-bit count from cfg_dbits, clamped to the rx_dout width
  always_comb begin
    dbits_cnt_s = {2'b00, cfg_dbits} + 4'(DBITS_BASE);
    if (dbits_cnt_s > 4'(DBIT_MAX)) begin
      dbits_cnt_s = 4'(DBIT_MAX);
    end else begin
      dbits_cnt_s = dbits_cnt_s;
    end
  end

  // Receiver FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      s_r        <= '0;
      n_r        <= '0;
      data_r     <= '0;
      xor_r      <= 1'b0;
      zero_r     <= 1'b0;
      ferr_r     <= 1'b0;
      perr_r     <= 1'b0;
      stop_sec_r <= 1'b0;
      last_n_r   <= '0;
      par_en_r   <= 1'b0;
      par_odd_r  <= 1'b0;
      stop2_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      s_r        <= s_nxt_s;
      n_r        <= n_nxt_s;
      data_r     <= data_nxt_s;
      xor_r      <= xor_nxt_s;
      zero_r     <= zero_nxt_s;
      ferr_r     <= ferr_nxt_s;
      perr_r     <= perr_nxt_s;
      stop_sec_r <= stop_sec_nxt_s;
      last_n_r   <= last_n_nxt_s;
      par_en_r   <= par_en_nxt_s;
      par_odd_r  <= par_odd_nxt_s;
      stop2_r    <= stop2_nxt_s;
    end
  end

  // Next-state and datapath update; s counts from the mid start bit onward
  always_comb begin
    state_nxt_s    = state_r;
    s_nxt_s        = s_r;
    n_nxt_s        = n_r;
    data_nxt_s     = data_r;
    xor_nxt_s      = xor_r;
    zero_nxt_s     = zero_r;
    ferr_nxt_s     = ferr_r;
    perr_nxt_s     = perr_r;
    stop_sec_nxt_s = stop_sec_r;
    last_n_nxt_s   = last_n_r;
    par_en_nxt_s   = par_en_r;
    par_odd_nxt_s  = par_odd_r;
    stop2_nxt_s    = stop2_r;
    done_nxt_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (!rxs_s) begin
          state_nxt_s    = START;
          s_nxt_s        = '0;
          data_nxt_s     = '0;
          xor_nxt_s      = 1'b0;
          zero_nxt_s     = 1'b1;
          ferr_nxt_s     = 1'b0;
          perr_nxt_s     = 1'b0;
          stop_sec_nxt_s = 1'b0;
          last_n_nxt_s   = NW'(dbits_cnt_s - 4'd1);
          par_en_nxt_s   = cfg_par_en;
          par_odd_nxt_s  = cfg_par_odd;
          stop2_nxt_s    = cfg_stop2;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_r == S_HALF) begin
            if (bit_s) begin
              state_nxt_s = IDLE;   // line back high mid start bit: false start
            end else begin
              state_nxt_s = DATA;
              s_nxt_s     = '0;
              n_nxt_s     = '0;
            end
          end else begin
            s_nxt_s = s_r + S_ONE;
          end
        end else begin
          s_nxt_s = s_r;
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_r == S_LAST) begin
            data_nxt_s[n_r] = bit_s;
            xor_nxt_s       = xor_r ^ bit_s;
            zero_nxt_s      = zero_r & ~bit_s;
            s_nxt_s         = '0;
            if (n_r == last_n_r) begin
              if (par_en_r) begin
                state_nxt_s = PARITY;
              end else begin
                state_nxt_s = STOP;
              end
            end else begin
              n_nxt_s = n_r + N_ONE;
            end
          end else begin
            s_nxt_s = s_r + S_ONE;
          end
        end else begin
          s_nxt_s = s_r;
        end
      end

      PARITY: begin
        if (s_tick) begin
          if (s_r == S_LAST) begin
            // even: error when total XOR is 1; odd: error when it is 0
            perr_nxt_s  = xor_r ^ bit_s ^ par_odd_r;
            zero_nxt_s  = zero_r & ~bit_s;
            s_nxt_s     = '0;
            state_nxt_s = STOP;
          end else begin
            s_nxt_s = s_r + S_ONE;
          end
        end else begin
          s_nxt_s = s_r;
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_r == S_LAST) begin
            s_nxt_s = '0;
            if (!bit_s) begin
              ferr_nxt_s = 1'b1;
            end else begin
              ferr_nxt_s = ferr_r;
            end
            // only the first stop bit participates in break detection
            if (!stop_sec_r) begin
              zero_nxt_s = zero_r & ~bit_s;
            end else begin
              zero_nxt_s = zero_r;
            end
            if (stop2_r && !stop_sec_r) begin
              stop_sec_nxt_s = 1'b1;
            end else begin
              state_nxt_s = IDLE;
              done_nxt_s  = 1'b1;
            end
          end else begin
            s_nxt_s = s_r + S_ONE;
          end
        end else begin
          s_nxt_s = s_r;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Status outputs: published together with the done pulse, held until the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_dout_r  <= '0;
      done_r     <= 1'b0;
      perr_out_r <= 1'b0;
      ferr_out_r <= 1'b0;
      brk_out_r  <= 1'b0;
    end else if (done_nxt_s) begin
      rx_dout_r  <= data_nxt_s;
      done_r     <= 1'b1;
      perr_out_r <= perr_nxt_s;
      ferr_out_r <= ferr_nxt_s;
      brk_out_r  <= zero_nxt_s;
    end else begin
      done_r <= 1'b0;
    end
  end

  assign rx_dout      = rx_dout_r;
  assign rx_done_tick = done_r;
  assign parity_err   = perr_out_r;
  assign frame_err    = ferr_out_r;
  assign break_det    = brk_out_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

  localparam int DBIT_MAX = 8;
  localparam int OVS      = 16;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic s_tick;
  logic [1:0] cfg_dbits;
  logic cfg_par_en;
  logic cfg_par_odd;
  logic cfg_stop2;
  logic [DBIT_MAX-1:0] rx_dout;
  logic rx_done_tick;
  logic parity_err;
  logic frame_err;
  logic break_det;

  uart_rx_cfg #(.DBIT_MAX(DBIT_MAX), .OVS(OVS)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .cfg_dbits    (cfg_dbits),
    .cfg_par_en   (cfg_par_en),
    .cfg_par_odd  (cfg_par_odd),
    .cfg_stop2    (cfg_stop2),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .break_det    (break_det)
  );

  always #5 clk = ~clk;

  // s_tick every 4th clock; a "slot" is the 4 clocks ending in one s_tick
  logic [1:0] div = 2'd0;
  always @(posedge clk) div <= div + 2'd1;
  assign s_tick = (div == 2'd3);

  typedef struct packed {
    logic [1:0] dbits;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
    logic [7:0] data;
    logic       par_bit;
    logic       stop1v;
    logic       stop2v;
    logic       swap;      // scramble cfg_* after the start bit
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  typedef struct packed {
    logic [7:0] dout;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  exp_t last_exp;
  vec_t tbl[12];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard: pop the expected frame result on every done pulse
  always @(negedge clk) begin
    if (!reset && rx_done_tick) begin
      done_cnt++;
      chk("done_width", 32'(done_prev), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: got rx_dout 0x%0h, expected no frame", rx_dout);
      end else begin
        e_mon = exp_q.pop_front();
        chk("rx_dout", 32'(rx_dout), 32'(e_mon.dout));
        chk("parity_err", 32'(parity_err), 32'(e_mon.perr));
        chk("frame_err", 32'(frame_err), 32'(e_mon.ferr));
        chk("break_det", 32'(break_det), 32'(e_mon.brk));
        last_exp = e_mon;
      end
    end
    done_prev = rx_done_tick;
  end

  task automatic align();
    while (div != 2'd0) @(negedge clk);
  endtask

  task automatic slots(input logic v, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      rx = v;
      repeat (4) @(negedge clk);
    end
  endtask

  // Drive one frame; the last bit is released high right after its mid sample.
  // glitch_slot (1-based, 0 = none) inverts the line for that single slot.
  task automatic send_frame(input vec_t v, input int glitch_slot);
    logic [15:0] bits;
    int nb;
    int slot;
    bits = '0;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < int'(v.dbits) + 5; i++) begin
      bits[nb] = v.data[i]; nb++;
    end
    if (v.par_en) begin
      bits[nb] = v.par_bit; nb++;
    end
    bits[nb] = v.stop1v; nb++;
    if (v.stop2) begin
      bits[nb] = v.stop2v; nb++;
    end
    cfg_dbits   = v.dbits;
    cfg_par_en  = v.par_en;
    cfg_par_odd = v.par_odd;
    cfg_stop2   = v.stop2;
    align();
    slot = 0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < OVS; k++) begin
        slot++;
        if (b == nb - 1 && k >= OVS / 2) rx = 1'b1;
        else if (slot == glitch_slot) rx = ~bits[b];
        else rx = bits[b];
        if (v.swap && b == 1 && k == 0) begin
          cfg_dbits   = ~v.dbits;
          cfg_par_en  = ~v.par_en;
          cfg_par_odd = ~v.par_odd;
          cfg_stop2   = ~v.stop2;
        end
        repeat (4) @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic p, input logic f, input logic b);
    exp_t t;
    t.dout = d; t.perr = p; t.ferr = f; t.brk = b;
    exp_q.push_back(t);
  endtask

  task automatic check_outputs(input string nm, input exp_t e);
    chk({nm, "_dout"}, 32'(rx_dout), 32'(e.dout));
    chk({nm, "_perr"}, 32'(parity_err), 32'(e.perr));
    chk({nm, "_ferr"}, 32'(frame_err), 32'(e.ferr));
    chk({nm, "_brk"}, 32'(break_det), 32'(e.brk));
  endtask

  initial begin : main
    int cnt0;
    exp_t zero_e;
    vec_t v;
    zero_e = '0;

    //          dbits par  odd  st2  data   pbit s1   s2   swap  exp    pe   fe   brk
    tbl[0]  = '{2'd3, 1'b0,1'b0,1'b0,8'hA5, 1'b0,1'b1,1'b1,1'b0, 8'hA5, 1'b0,1'b0,1'b0};
    tbl[1]  = '{2'd2, 1'b1,1'b0,1'b0,8'h35, 1'b0,1'b1,1'b1,1'b0, 8'h35, 1'b0,1'b0,1'b0};
    tbl[2]  = '{2'd2, 1'b1,1'b0,1'b0,8'h35, 1'b1,1'b1,1'b1,1'b0, 8'h35, 1'b1,1'b0,1'b0};
    tbl[3]  = '{2'd0, 1'b1,1'b1,1'b1,8'h1F, 1'b0,1'b1,1'b0,1'b0, 8'h1F, 1'b0,1'b1,1'b0};
    tbl[4]  = '{2'd1, 1'b1,1'b0,1'b0,8'h2A, 1'b1,1'b1,1'b1,1'b0, 8'h2A, 1'b0,1'b0,1'b0};
    tbl[5]  = '{2'd3, 1'b1,1'b1,1'b0,8'h00, 1'b1,1'b1,1'b1,1'b0, 8'h00, 1'b0,1'b0,1'b0};
    tbl[6]  = '{2'd3, 1'b0,1'b0,1'b1,8'h81, 1'b0,1'b1,1'b1,1'b0, 8'h81, 1'b0,1'b0,1'b0};
    tbl[7]  = '{2'd0, 1'b0,1'b0,1'b0,8'hFF, 1'b0,1'b1,1'b1,1'b0, 8'h1F, 1'b0,1'b0,1'b0};
    tbl[8]  = '{2'd3, 1'b1,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0, 8'h00, 1'b0,1'b1,1'b1};
    tbl[9]  = '{2'd3, 1'b0,1'b0,1'b0,8'hC3, 1'b0,1'b1,1'b1,1'b1, 8'hC3, 1'b0,1'b0,1'b0};
    tbl[10] = '{2'd2, 1'b1,1'b1,1'b1,8'h55, 1'b0,1'b0,1'b1,1'b0, 8'h55, 1'b1,1'b1,1'b0};
    tbl[11] = '{2'd3, 1'b0,1'b0,1'b1,8'h00, 1'b0,1'b0,1'b1,1'b0, 8'h00, 1'b0,1'b1,1'b1};

    rx = 1'b1;
    reset = 1'b1;
    cfg_dbits = 2'd3; cfg_par_en = 1'b0; cfg_par_odd = 1'b0; cfg_stop2 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("reset", zero_e);
    chk("reset_done", 32'(rx_done_tick), 32'd0);
    align();
    slots(1'b1, 4);

    // Table-driven frames
    for (int i = 0; i < 12; i++) begin
      cnt0 = done_cnt;
      push_exp(tbl[i].exp_dout, tbl[i].exp_perr, tbl[i].exp_ferr, tbl[i].exp_brk);
      send_frame(tbl[i], 0);
      slots(1'b1, 20);
      chk($sformatf("vec%0d_done_cnt", i), 32'(done_cnt), 32'(cnt0 + 1));
      chk($sformatf("vec%0d_queue", i), 32'(exp_q.size()), 32'd0);
    end

    // Short low glitch: false start rejected, outputs hold
    cnt0 = done_cnt;
    align();
    slots(1'b0, 3);
    slots(1'b1, 30);
    chk("glitch_no_done", 32'(done_cnt), 32'(cnt0));
    check_outputs("glitch_hold", last_exp);

    // 12-bit-period break; the FSM re-arms on the still-low line and
    // frames a second byte whose bits 0..1 fall inside the break
    cnt0 = done_cnt;
    cfg_dbits = 2'd3; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    push_exp(8'h00, 1'b0, 1'b1, 1'b1);
    push_exp(8'hFC, 1'b0, 1'b0, 1'b0);
    align();
    slots(1'b0, 12 * OVS);
    slots(1'b1, 200);
    chk("break_done_cnt", 32'(done_cnt), 32'(cnt0 + 2));
    chk("break_queue", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of DATA aborts silently
    cnt0 = done_cnt;
    align();
    slots(1'b0, OVS);
    slots(1'b1, OVS);
    slots(1'b0, OVS / 2);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("midreset", zero_e);
    slots(1'b1, 40);
    chk("midreset_no_done", 32'(done_cnt), 32'(cnt0));
    check_outputs("midreset_hold", zero_e);

    v = tbl[0];
    v.data = 8'h3C; v.exp_dout = 8'h3C;
    push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(v, 0);
    slots(1'b1, 20);
    chk("after_reset_done_cnt", 32'(done_cnt), 32'(cnt0 + 1));

    // Single-slot low glitch at the mid of data bit 2 of 0xFF
    cnt0 = done_cnt;
    v = tbl[0];
    v.data = 8'hFF;
`ifdef UART_RX_MAJORITY_VOTE_EN
    push_exp(8'hFF, 1'b0, 1'b0, 1'b0);
`else
    push_exp(8'hFB, 1'b0, 1'b0, 1'b0);
`endif
    send_frame(v, 3 * OVS + OVS / 2);
    slots(1'b1, 20);
    chk("vote_done_cnt", 32'(done_cnt), 32'(cnt0 + 1));
    chk("vote_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
